// File: rtl/aes_shift_rows_pipe.sv
// AES ShiftRows / InvShiftRows stage followed by a small circular result FIFO.
// The byte permutation is pure wiring selected per push by in_inv; each FIFO
// entry carries its own mode bit so forward and inverse results may interleave.
module aes_shift_rows_pipe #(
   parameter int NB    = 4,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_inv,
   input  logic [32*NB-1:0]         in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [32*NB-1:0]         out_data,
   output logic                     out_inv,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int W  = 32 * NB;
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   // Reject unsupported geometries at elaboration rather than building a wrong permutation
   if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
      $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("aes_shift_rows_pipe: DEPTH must be a power of two and at least 2");
   end

   logic [W-1:0]  fwd_data;
   logic [W-1:0]  inv_data;
   logic [W-1:0]  shifted;
   logic [W:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          push;
   logic          pop;

   // Byte k lives at bits [W-1-8k -: 8]; row r is rotated left by its offset
   // for the forward transform and right by the same offset for the inverse.
   for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int OFF = (r == 0) ? 0 :
                           (r == 1) ? 1 :
                           (r == 2) ? ((NB == 8) ? 3 : 2) :
                                      ((NB == 8) ? 4 : 3);
      for (genvar c = 0; c < NB; c++) begin : g_col
         localparam int K  = r * NB + c;
         localparam int FS = r * NB + (c + OFF) % NB;
         localparam int IS = r * NB + (c - OFF + NB) % NB;
         assign fwd_data[W-1-8*K -: 8] = in_data[W-1-8*FS -: 8];
         assign inv_data[W-1-8*K -: 8] = in_data[W-1-8*IS -: 8];
      end
   end

   assign shifted = in_inv ? inv_data : fwd_data;

   // Handshake flags come only from the registered level, so out_ready never
   // reaches in_ready combinationally; flush suppresses both transfers.
   assign in_ready  = (level < DEPTH_L);
   assign out_valid = (level != '0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready && !flush;

   // Storage is left uninitialised; the empty case is masked to zero below
   assign out_data = out_valid ? mem[rd_ptr][W-1:0] : '0;
   assign out_inv  = out_valid ? mem[rd_ptr][W]     : 1'b0;

   // Write the transformed state and its mode bit at the tail on every push
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_inv, shifted};
      end
   end

   // Pointer and occupancy bookkeeping; power-of-two depth lets pointers wrap naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Scoreboard bench for aes_shift_rows_pipe: one NB=4/DEPTH=2 instance and one
// NB=8/DEPTH=4 instance, driven with hand-computed vectors.
module tb_aes_shift_rows_pipe;

   typedef struct packed {
      logic         inv;
      logic [255:0] data;
   } exp_t;

   localparam logic [127:0] A4 = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] F4 = 128'h00010203_05060704_0A0B0809_0F0C0D0E;
   localparam logic [127:0] I4 = 128'h00010203_07040506_0A0B0809_0D0E0F0C;
   localparam logic [255:0] A8 = 256'h0001020304050607_08090A0B0C0D0E0F_1011121314151617_18191A1B1C1D1E1F;
   localparam logic [255:0] F8 = 256'h0001020304050607_090A0B0C0D0E0F08_1314151617101112_1C1D1E1F18191A1B;
   localparam logic [255:0] I8 = 256'h0001020304050607_0F08090A0B0C0D0E_1516171011121314_1C1D1E1F18191A1B;

   logic clk = 1'b0;
   logic rst;

   logic         flush4, in_valid4, in_ready4, in_inv4, out_valid4, out_ready4, out_inv4;
   logic [127:0] in_data4, out_data4;
   logic [1:0]   level4;

   logic         flush8, in_valid8, in_ready8, in_inv8, out_valid8, out_ready8, out_inv8;
   logic [255:0] in_data8, out_data8;
   logic [2:0]   level8;

   exp_t q4[$];
   exp_t q8[$];
   exp_t e4, e8;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   aes_shift_rows_pipe #(.NB(4), .DEPTH(2)) u_dut4 (
      .clk(clk), .rst(rst), .flush(flush4),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_inv(in_inv4), .in_data(in_data4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
      .out_inv(out_inv4), .level(level4)
   );

   aes_shift_rows_pipe #(.NB(8), .DEPTH(4)) u_dut8 (
      .clk(clk), .rst(rst), .flush(flush8),
      .in_valid(in_valid8), .in_ready(in_ready8), .in_inv(in_inv8), .in_data(in_data8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
      .out_inv(out_inv8), .level(level8)
   );

   // A uniform per-byte XOR commutes with any byte permutation, so shifted(A^p) = shifted(A)^p
   function automatic logic [127:0] pat4(input int i);
      logic [7:0] b;
      b = 8'(i * 29 + 3);
      return {16{b}};
   endfunction

   function automatic logic [255:0] pat8(input int i);
      logic [7:0] b;
      b = 8'(i * 53 + 7);
      return {32{b}};
   endfunction

   task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one input beat; the expectation is queued only if the DUT will take it
   task automatic apply_stimulus4(input logic valid, input logic inv, input logic [127:0] data,
                                  input logic [127:0] exp_data);
      exp_t e;
      in_valid4 = valid;
      in_inv4   = inv;
      in_data4  = data;
      if (valid && in_ready4 && !flush4) begin
         e.inv  = inv;
         e.data = 256'(exp_data);
         q4.push_back(e);
      end
   endtask

   task automatic apply_stimulus8(input logic valid, input logic inv, input logic [255:0] data,
                                  input logic [255:0] exp_data);
      exp_t e;
      in_valid8 = valid;
      in_inv8   = inv;
      in_data8  = data;
      if (valid && in_ready8 && !flush8) begin
         e.inv  = inv;
         e.data = exp_data;
         q8.push_back(e);
      end
   endtask

   // Monitor for the NB=4 instance: compare the head on every pop
   always @(negedge clk) begin
      if (!rst && !flush4 && out_valid4 && out_ready4) begin
         if (q4.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_out4: got %0h, expected no output", out_data4);
         end else begin
            e4 = q4.pop_front();
            check_output("out_data4", 256'(out_data4), e4.data);
            check_output("out_inv4", 256'(out_inv4), 256'(e4.inv));
         end
      end
   end

   // Monitor for the NB=8 instance
   always @(negedge clk) begin
      if (!rst && !flush8 && out_valid8 && out_ready8) begin
         if (q8.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_out8: got %0h, expected no output", out_data8);
         end else begin
            e8 = q8.pop_front();
            check_output("out_data8", out_data8, e8.data);
            check_output("out_inv8", 256'(out_inv8), 256'(e8.inv));
         end
      end
   end

   // Directed sequence
   initial begin
      rst = 1'b1;
      flush4 = 1'b0; in_valid4 = 1'b0; in_inv4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0;
      flush8 = 1'b0; in_valid8 = 1'b0; in_inv8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
      #2;
      check_output("rst_level4", 256'(level4), 256'(0));
      check_output("rst_out_valid4", 256'(out_valid4), 256'(0));
      check_output("rst_in_ready4", 256'(in_ready4), 256'(1));
      check_output("rst_out_data4", 256'(out_data4), 256'(0));
      check_output("rst_out_inv4", 256'(out_inv4), 256'(0));
      check_output("rst_level8", 256'(level8), 256'(0));
      tick();
      tick();

      // First push right after reset release, then fill and hold the consumer off
      rst = 1'b0;
      apply_stimulus4(1'b1, 1'b0, A4, F4);
      check_output("first_in_ready4", 256'(in_ready4), 256'(1));
      tick();
      check_output("latency_valid4", 256'(out_valid4), 256'(1));
      check_output("latency_level4", 256'(level4), 256'(1));
      apply_stimulus4(1'b1, 1'b1, A4, I4);
      tick();
      check_output("full_level4", 256'(level4), 256'(2));
      check_output("full_in_ready4", 256'(in_ready4), 256'(0));
      apply_stimulus4(1'b1, 1'b0, A4 ^ pat4(40), F4 ^ pat4(40));
      tick();
      check_output("refused_level4", 256'(level4), 256'(2));
      check_output("stall_out_data4", 256'(out_data4), 256'(F4));
      in_data4 = ~A4;
      in_inv4  = 1'b1;
      tick();
      check_output("ignored_in_level4", 256'(level4), 256'(2));
      check_output("stable_out_data4", 256'(out_data4), 256'(F4));
      check_output("stable_out_inv4", 256'(out_inv4), 256'(0));

      // Release: full means refused even with a pop, then the third enters
      out_ready4 = 1'b1;
      apply_stimulus4(1'b1, 1'b0, A4 ^ pat4(40), F4 ^ pat4(40));
      tick();
      check_output("pop_only_level4", 256'(level4), 256'(1));
      apply_stimulus4(1'b1, 1'b0, A4 ^ pat4(40), F4 ^ pat4(40));
      tick();
      check_output("push_pop_level4", 256'(level4), 256'(1));
      apply_stimulus4(1'b0, 1'b0, '0, '0);
      tick();
      check_output("drained_level4", 256'(level4), 256'(0));
      check_output("drained_valid4", 256'(out_valid4), 256'(0));
      check_output("empty_out_data4", 256'(out_data4), 256'(0));

      // Inverse result fed back forward restores the original state
      apply_stimulus4(1'b1, 1'b0, I4, A4);
      tick();
      apply_stimulus4(1'b0, 1'b0, '0, '0);
      tick();
      tick();

      // Steady push+pop at level 1 across several pointer wraps, mixed modes
      out_ready4 = 1'b0;
      apply_stimulus4(1'b1, 1'b0, A4 ^ pat4(0), F4 ^ pat4(0));
      tick();
      check_output("wrap_start_level4", 256'(level4), 256'(1));
      out_ready4 = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         if (i % 2 == 1) apply_stimulus4(1'b1, 1'b1, A4 ^ pat4(i), I4 ^ pat4(i));
         else            apply_stimulus4(1'b1, 1'b0, A4 ^ pat4(i), F4 ^ pat4(i));
         tick();
         check_output("wrap_level4", 256'(level4), 256'(1));
      end
      apply_stimulus4(1'b0, 1'b0, '0, '0);
      tick();
      check_output("wrap_end_level4", 256'(level4), 256'(0));

      // Flush from full with an input offered
      out_ready4 = 1'b0;
      apply_stimulus4(1'b1, 1'b0, A4 ^ pat4(20), F4 ^ pat4(20));
      tick();
      apply_stimulus4(1'b1, 1'b1, A4 ^ pat4(21), I4 ^ pat4(21));
      tick();
      check_output("pre_flush_level4", 256'(level4), 256'(2));
      flush4 = 1'b1;
      apply_stimulus4(1'b1, 1'b0, A4 ^ pat4(22), F4 ^ pat4(22));
      q4.delete();
      tick();
      flush4 = 1'b0;
      apply_stimulus4(1'b0, 1'b0, '0, '0);
      check_output("flush_full_level4", 256'(level4), 256'(0));
      check_output("flush_full_valid4", 256'(out_valid4), 256'(0));

      // Flush at level 1 with both a push and a pop requested
      apply_stimulus4(1'b1, 1'b0, A4 ^ pat4(23), F4 ^ pat4(23));
      tick();
      flush4 = 1'b1;
      out_ready4 = 1'b1;
      apply_stimulus4(1'b1, 1'b1, A4 ^ pat4(24), I4 ^ pat4(24));
      q4.delete();
      tick();
      flush4 = 1'b0;
      apply_stimulus4(1'b0, 1'b0, '0, '0);
      check_output("flush_push_level4", 256'(level4), 256'(0));
      tick();
      check_output("flush_dropped_level4", 256'(level4), 256'(0));

      // Reset mid-stream clears everything without waiting for a clock edge
      out_ready4 = 1'b0;
      apply_stimulus4(1'b1, 1'b0, A4 ^ pat4(30), F4 ^ pat4(30));
      tick();
      apply_stimulus4(1'b1, 1'b0, A4 ^ pat4(31), F4 ^ pat4(31));
      tick();
      apply_stimulus4(1'b0, 1'b0, '0, '0);
      check_output("pre_rst_level4", 256'(level4), 256'(2));
      #2;
      rst = 1'b1;
      #1;
      check_output("async_rst_valid4", 256'(out_valid4), 256'(0));
      check_output("async_rst_level4", 256'(level4), 256'(0));
      check_output("async_rst_in_ready4", 256'(in_ready4), 256'(1));
      check_output("async_rst_data4", 256'(out_data4), 256'(0));
      q4.delete();
      tick();
      rst = 1'b0;
      out_ready4 = 1'b1;
      apply_stimulus4(1'b1, 1'b1, A4, I4);
      tick();
      check_output("post_rst_valid4", 256'(out_valid4), 256'(1));
      apply_stimulus4(1'b0, 1'b0, '0, '0);
      tick();
      check_output("post_rst_level4", 256'(level4), 256'(0));

      // NB=8 geometry: fill the 4-deep buffer, then stream through a wrap
      apply_stimulus8(1'b1, 1'b0, A8, F8);
      tick();
      apply_stimulus8(1'b1, 1'b1, A8, I8);
      tick();
      apply_stimulus8(1'b1, 1'b0, A8 ^ pat8(1), F8 ^ pat8(1));
      tick();
      apply_stimulus8(1'b1, 1'b1, A8 ^ pat8(2), I8 ^ pat8(2));
      tick();
      check_output("full_level8", 256'(level8), 256'(4));
      check_output("full_in_ready8", 256'(in_ready8), 256'(0));
      check_output("head_data8", out_data8, F8);
      out_ready8 = 1'b1;
      for (int i = 3; i < 9; i++) begin
         if (i % 2 == 1) apply_stimulus8(1'b1, 1'b1, A8 ^ pat8(i), I8 ^ pat8(i));
         else            apply_stimulus8(1'b1, 1'b0, A8 ^ pat8(i), F8 ^ pat8(i));
         tick();
      end
      apply_stimulus8(1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 6; i++) tick();
      check_output("drained_level8", 256'(level8), 256'(0));

      check_output("scoreboard_empty4", 256'(q4.size()), 256'(0));
      check_output("scoreboard_empty8", 256'(q8.size()), 256'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
